// File: rtl/ram_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data load/store; data has fixed priority.
// Optional one-entry fetch buffer enabled by defining RAM_ARB_IBUF_EN.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, next_state;

  logic op_store, op_store_next;
  logic grant_data_c, grant_fetch_c, ibuf_take_c;
  logic fetch_done_c, data_done_c;
  logic ren_next_c, wen_next_c;
  logic ibuf_match_c;
  logic [DATA_W-1:0] ibuf_rdata_c;

  // Next-state and grant decode
  always_comb begin
    next_state    = state;
    op_store_next = op_store;
    grant_data_c  = 1'b0;
    grant_fetch_c = 1'b0;
    ibuf_take_c   = 1'b0;
    case (state)
      IDLE: begin
        if (dwen || dren) begin
          next_state    = DBUSY;
          grant_data_c  = 1'b1;
          op_store_next = dwen;
        end else if (iren) begin
          if (ibuf_match_c) begin
            next_state  = RESP;
            ibuf_take_c = 1'b1;
          end else begin
            next_state    = IBUSY;
            grant_fetch_c = 1'b1;
          end
        end
      end
      IBUSY: begin
        if (ram_ready) next_state = RESP;
      end
      DBUSY: begin
        if (ram_ready) next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign fetch_done_c = (state == IBUSY) && ram_ready;
  assign data_done_c  = (state == DBUSY) && ram_ready;

  // Strobes are registered from the next state so they track the state exactly
  assign ren_next_c = (next_state == IBUSY) || ((next_state == DBUSY) && !op_store_next);
  assign wen_next_c = (next_state == DBUSY) && op_store_next;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      op_store <= 1'b0;
    end else begin
      state    <= next_state;
      op_store <= op_store_next;
    end
  end

  // Registered outputs and request latches
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      imemload  <= '0;
      dmemload  <= '0;
    end else begin
      ram_ren <= ren_next_c;
      ram_wen <= wen_next_c;
      ihit    <= fetch_done_c || ibuf_take_c;
      dhit    <= data_done_c;
      if (grant_data_c) begin
        ram_addr  <= daddr;
        ram_store <= dstore;
      end else if (grant_fetch_c) begin
        ram_addr <= iaddr;
      end
      if (fetch_done_c) begin
        imemload <= ram_load;
      end else if (ibuf_take_c) begin
        imemload <= ibuf_rdata_c;
      end
      if (data_done_c && !op_store) begin
        dmemload <= ram_load;
      end
    end
  end

`ifdef RAM_ARB_IBUF_EN
  logic              ibuf_valid;
  logic [ADDR_W-1:0] ibuf_addr;
  logic [DATA_W-1:0] ibuf_data;

  assign ibuf_match_c = ibuf_valid && (iaddr == ibuf_addr);
  assign ibuf_rdata_c = ibuf_data;

  // Fill on every RAM fetch; drop the entry when a store overwrites its address
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ibuf_valid <= 1'b0;
      ibuf_addr  <= '0;
      ibuf_data  <= '0;
    end else if (fetch_done_c) begin
      ibuf_valid <= 1'b1;
      ibuf_addr  <= ram_addr;
      ibuf_data  <= ram_load;
    end else if (data_done_c && op_store && (ram_addr == ibuf_addr)) begin
      ibuf_valid <= 1'b0;
    end
  end
`else
  assign ibuf_match_c = 1'b0;
  assign ibuf_rdata_c = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter against a transaction-level reference model.
module tb_ram_arbiter;

  logic        clk;
  logic        nRST;
  logic        iren;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;

  int total = 0;
  int bad   = 0;

`ifdef RAM_ARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  // Reference model: last completed results and the fetch buffer contents
  logic [31:0] m_imem;
  logic [31:0] m_dmem;
  bit          m_bv;
  logic [31:0] m_ba;
  logic [31:0] m_bd;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nRST(nRST),
    .iren(iren), .iaddr(iaddr), .ihit(ihit), .imemload(imemload),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dmemload(dmemload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_imem = '0;
    m_dmem = '0;
    m_bv   = 1'b0;
    m_ba   = '0;
    m_bd   = '0;
  endtask

  // One complete access from an IDLE cycle through its RESP cycle, checked cycle by cycle
  task automatic run_access(input bit i, input bit r, input bit w,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] ds, input logic [31:0] ld,
                            input int k, input bit drop);
    bit is_data;
    bit is_store;
    bit bufhit;
    logic [31:0] exp_addr;
    is_data  = r || w;
    is_store = w;
    bufhit   = !is_data && i && m_bv && (ia == m_ba);
    exp_addr = is_data ? da : ia;
    @(negedge clk);
    total++;
    if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_outputs: got ihit,dhit,ren,wen=%b want 0000", {ihit, dhit, ram_ren, ram_wen});
    end
    iren = i; dren = r; dwen = w;
    iaddr = ia; daddr = da; dstore = ds;
    ram_ready = 1'($urandom); ram_load = $urandom;
    @(posedge clk);
    if (!bufhit) begin
      for (int c = 1; c <= k; c++) begin
        @(negedge clk);
        total++;
        if (ram_ren !== (!is_data || !is_store) || ram_wen !== (is_data && is_store)) begin
          bad++;
          $display("FAIL busy_strobes: cycle %0d got ren=%b wen=%b want ren=%b wen=%b",
                   c, ram_ren, ram_wen, (!is_data || !is_store), (is_data && is_store));
        end
        total++;
        if (ram_addr !== exp_addr) begin
          bad++;
          $display("FAIL busy_addr: cycle %0d got %h want %h", c, ram_addr, exp_addr);
        end
        if (is_store) begin
          total++;
          if (ram_store !== ds) begin
            bad++;
            $display("FAIL busy_store_data: got %h want %h", ram_store, ds);
          end
        end
        total++;
        if (ihit !== 1'b0 || dhit !== 1'b0) begin
          bad++;
          $display("FAIL early_hit: cycle %0d got ihit=%b dhit=%b want 0 0", c, ihit, dhit);
        end
        if (drop && c == 1) begin
          iren = 1'b0; dren = 1'b0; dwen = 1'b0;
          iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        end
        ram_ready = (c == k);
        ram_load  = ld;
        @(posedge clk);
      end
    end
    @(negedge clk);
    if (bufhit) begin
      m_imem = m_bd;
    end else if (!is_data) begin
      m_imem = ld;
      if (IBUF) begin
        m_bv = 1'b1; m_ba = ia; m_bd = ld;
      end
    end else if (!is_store) begin
      m_dmem = ld;
    end else if (m_bv && m_ba == da) begin
      m_bv = 1'b0;
    end
    total++;
    if (ihit !== !is_data || dhit !== is_data) begin
      bad++;
      $display("FAIL hit_pulse: got ihit=%b dhit=%b want ihit=%b dhit=%b", ihit, dhit, !is_data, is_data);
    end
    total++;
    if (imemload !== m_imem) begin
      bad++;
      $display("FAIL imemload: got %h want %h", imemload, m_imem);
    end
    total++;
    if (dmemload !== m_dmem) begin
      bad++;
      $display("FAIL dmemload: got %h want %h", dmemload, m_dmem);
    end
    total++;
    if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin
      bad++;
      $display("FAIL resp_strobes: got ren=%b wen=%b want 0 0", ram_ren, ram_wen);
    end
    iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    ram_ready = 1'($urandom); ram_load = $urandom;
    @(posedge clk);
  endtask

  // Idle cycles with stray ram_ready that must be ignored
  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      total++;
      if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0000) begin
        bad++;
        $display("FAIL gap_outputs: got ihit,dhit,ren,wen=%b want 0000", {ihit, dhit, ram_ren, ram_wen});
      end
      ram_ready = 1'($urandom); ram_load = $urandom;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_load = '0; ram_ready = 1'b0;
    #2 nRST = 1'b0;
    #1;
    model_reset();
    total++;
    if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {ihit, dhit, ram_ren, ram_wen});
    end
    total++;
    if (imemload !== 32'h0 || dmemload !== 32'h0 || ram_addr !== 32'h0 || ram_store !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got imem=%h dmem=%h addr=%h store=%h want all 0",
               imemload, dmemload, ram_addr, ram_store);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_fetch();
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0050_0093, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    iren = 1'b1; iaddr = 32'h0000_0080; ram_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ram_ren !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy_ren: got %b want 1", ram_ren);
    end
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    model_reset();
    total++;
    if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_ctrl: got %b want 0000", {ihit, dhit, ram_ren, ram_wen});
    end
    total++;
    if (imemload !== 32'h0 || ram_addr !== 32'h0 || dmemload !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_data: got imem=%h addr=%h dmem=%h want 0", imemload, ram_addr, dmemload);
    end
    iren = 1'b0;
    ram_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_idle: got %b want 0000", {ihit, dhit, ram_ren, ram_wen});
    end
    ram_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_priority();
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 32'h0000_0013, 1, 1'b0);
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_0000, 2, 1'b0);
  endtask

  task automatic test_store_wins();
    run_access(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0204, 32'hCAFE_F00D, 32'h5555_AAAA, 1, 1'b0);
  endtask

  task automatic test_ibuf();
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0050_0093, 2, 1'b0);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h1111_1111, 2, 1'b0);
    run_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0040, 32'h0000_0513, 32'h0, 1, 1'b0);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0000_0513, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pool_addr;
    int kind;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: pool_addr = 32'h0000_0040;
        1: pool_addr = 32'h0000_0044;
        2: pool_addr = 32'h0000_0080;
        default: pool_addr = $urandom;
      endcase
      kind = $urandom_range(0, 3);
      run_access((kind == 0) ? 1'b1 : 1'($urandom),
                 (kind == 1) || (kind == 3),
                 (kind == 2) || (kind == 3),
                 pool_addr, pool_addr, $urandom, $urandom,
                 $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
      idle_gap($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_reset_mid();
    test_priority();
    test_store();
    test_store_wins();
    test_ibuf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
